controller_seq: RTL and testbench
=================================

# controller_seq

Multi-cycle, parametrised sequencing controller for the teaching CPU datapath. It replaces the single-level combinational decoder with a registered state machine: IDLE, FETCH, EXEC, HALT. Memory accesses use a ready handshake with a wait-state timeout. The block adds single-step mode and a retired-instruction counter. It drives the same PC, RAM, IR, register-file, ALU and I/O strobes, and decodes the opcode and register fields internally from the IR value.

## Interface
- IR_W, 8, instruction width; opcode = ir[IR_W-1 -: 4]; requires IR_W >= 4 + 2*RA_W
- RA_W, 2, register-address width; DR = ir[2*RA_W-1:RA_W], SR = ir[RA_W-1:0]
- WAIT_MAX, 15, maximum consecutive wait cycles on one memory access before a timeout error
- CNT_W, 16, retired-instruction counter width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  leaves IDLE or HALT; in HALT it also clears err; ignored in FETCH/EXEC
- step_mode  in  1  1 = return to IDLE after every retired instruction
- ir  in  IR_W  instruction register contents, valid from EXEC onward
- gf  in  1  ALU greater flag
- mem_ready  in  1  RAM completes the current ram_re/ram_we access this cycle
- ld_pc, in_pc  out  1  PC load / PC increment
- s  out  2  RAM address select: 00 = PC, 01 = SR register, 10 = DR register
- ram_re, ram_we  out  1  RAM read/write request, held until mem_ready
- ld_ir, reg_we, au_en, g_en, in_en, out_en, s0  out  1  datapath strobes
- ac  out  4  ALU opcode (= opcode field)
- DR, SR  out  RA_W  register addresses
- sm  out  1  1 in EXEC, else 0
- busy  out  1  state is FETCH or EXEC
- halted  out  1  state is HALT
- err  out  1  sticky memory-timeout flag
- instr_cnt  out  CNT_W  retired-instruction count, wraps

## Operation
- Opcodes: 0 MOVA, 1 MOVB (store), 2 MOVC (load), 3 MOVD, 4 ADD, 5 SUB, 6 JMP, 7 JG, 8 IN, 9 OUT, 10 MOVI, 15 HALT. 11–14 are NOP.
- IDLE: all strobes 0. start=1 -> FETCH.
- FETCH: s=00, ram_re=1.
  - With mem_ready=1: ld_ir=1, in_pc=1, -> EXEC.
- EXEC single-cycle ops. All of these retire, then go to FETCH, or to IDLE if step_mode=1.
  - MOVA: s0, reg_we, au_en.
  - MOVD: reg_we.
  - ADD: s0, reg_we, au_en.
  - SUB: s0, reg_we, au_en, g_en.
  - IN: s0, reg_we, in_en.
  - OUT: au_en, out_en.
  - JMP: ld_pc.
  - JG: ld_pc = gf.
  - NOP: no strobes.
- EXEC memory ops. These stay in EXEC until mem_ready, then retire.
  - MOVB: s=10, ram_we, au_en.
  - MOVC: s=01, ram_re, s0; reg_we only in the mem_ready cycle.
  - MOVI: s=00, ram_re, s0; reg_we and in_pc only in the mem_ready cycle.
- HALT opcode: retires, -> HALT.
- HALT state: strobes 0. start=1 -> FETCH and clears err.
- Retire: instr_cnt += 1 mod 2^CNT_W on the transition out of EXEC. A timed-out instruction does not retire.
- Wait counter:
  - Counts consecutive cycles with a pending request and mem_ready=0.
  - Reaching WAIT_MAX with mem_ready=0 sets err, drops the request and goes to HALT.
  - The counter clears on every state change and whenever mem_ready=1.
- ac, DR, SR follow ir combinationally in every state.

## Timing
- Reset (async, rst_n=0): state IDLE, instr_cnt=0, err=0, wait counter=0. Every strobe, sm, busy and halted is 0.
- Reset mid-access: requests drop immediately. No strobe glitches high after the rst_n deassertion edge.
- Outputs are a function of registered state plus ir, gf and mem_ready. Strobes gated by mem_ready are Mealy.
- Zero-wait latency:
  - Single-cycle op: 2 cycles (FETCH + EXEC).
  - Memory op: 2 cycles, plus 1 per wait cycle on each access.
- mem_ready=1 outside a request is ignored.
- start and halt: start in the same cycle that EXEC executes HALT is ignored, because the state is not yet HALT.
- step_mode is sampled in the retire cycle.

## Test plan
- Reset, start, program MOVI 0x5 then ADD, zero waits. Required: MOVI runs FETCH/EXEC with in_pc pulsed twice and reg_we in its EXEC. ADD asserts s0, reg_we, au_en with ac=4. instr_cnt=2 after 4 cycles.
- MOVC with mem_ready low for 3 cycles. Required: ram_re held 4 cycles at s=01, reg_we exactly 1 cycle coincident with mem_ready, err=0.
- MOVB with mem_ready never asserted, WAIT_MAX=15. Required: after 15 wait cycles err=1, halted=1, ram_we=0, instr_cnt unchanged. Then start: err=0, FETCH.
- JG with gf=0, then JG with gf=1. Required: ld_pc 0 in the first EXEC and 1 in the second. JMP gives ld_pc=1 unconditionally.
- step_mode=1 over 3 NOPs. Required: busy drops after each EXEC, and each instruction needs its own start pulse. instr_cnt increments by 1 per start.
- CNT_W=4, run 17 NOPs. Required: instr_cnt wraps to 1. rst_n pulsed low mid-FETCH: all outputs 0 within the same cycle, state IDLE.

Source files
------------

// File: rtl/controller_seq.sv
// controller_seq: multi-cycle sequencing controller for the teaching CPU datapath.
// A registered IDLE/FETCH/EXEC/HALT machine drives the PC, RAM, IR, register-file, ALU
// and I/O strobes from the opcode held in ir. RAM accesses wait on mem_ready, with a
// timeout that sets a sticky err flag and parks the machine in HALT.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 leave IDLE/HALT (also clears err when leaving HALT)
//   step_mode             return to IDLE after each retired instruction
//   ir, gf, mem_ready     instruction, ALU greater flag, RAM access completion
//   ld_pc, in_pc, s       PC load/increment, RAM address select (00 PC, 01 SR, 10 DR)
//   ram_re, ram_we        RAM read/write requests, held until mem_ready
//   ld_ir, reg_we, au_en, g_en, in_en, out_en, s0   datapath strobes
//   ac, DR, SR            opcode and register fields decoded from ir
//   sm, busy, halted      EXEC flag, FETCH/EXEC flag, HALT flag
//   err, instr_cnt        sticky timeout flag, wrapping retired-instruction count
module controller_seq #(
    parameter int unsigned IR_W     = 8,   // needs IR_W >= 4 + 2*RA_W
    parameter int unsigned RA_W     = 2,
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic [IR_W-1:0]  ir,
    input  logic             gf,
    input  logic             mem_ready,
    output logic             ld_pc,
    output logic             in_pc,
    output logic [1:0]       s,
    output logic             ram_re,
    output logic             ram_we,
    output logic             ld_ir,
    output logic             reg_we,
    output logic             au_en,
    output logic             g_en,
    output logic             in_en,
    output logic             out_en,
    output logic             s0,
    output logic [3:0]       ac,
    output logic [RA_W-1:0]  DR,
    output logic [RA_W-1:0]  SR,
    output logic             sm,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [1:0] {StIdle, StFetch, StExec, StHalt} state_e;

    localparam logic [3:0] OpMova = 4'd0;
    localparam logic [3:0] OpMovb = 4'd1;
    localparam logic [3:0] OpMovc = 4'd2;
    localparam logic [3:0] OpMovd = 4'd3;
    localparam logic [3:0] OpAdd  = 4'd4;
    localparam logic [3:0] OpSub  = 4'd5;
    localparam logic [3:0] OpJmp  = 4'd6;
    localparam logic [3:0] OpJg   = 4'd7;
    localparam logic [3:0] OpIn   = 4'd8;
    localparam logic [3:0] OpOut  = 4'd9;
    localparam logic [3:0] OpMovi = 4'd10;
    localparam logic [3:0] OpHalt = 4'd15;

    // Counter only has to reach WAIT_MAX-1: the wait cycle seen at that value is the last.
    localparam int unsigned WcW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam logic [WcW-1:0] WaitLast = WcW'(WAIT_MAX - 1);

    state_e           state_q, state_d;
    logic [WcW-1:0]   wait_q, wait_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0] opcode;
    logic       pending;
    logic       mem_op;

    assign opcode    = ir[IR_W-1 -: 4];
    assign ac        = opcode;
    assign DR        = ir[2*RA_W-1:RA_W];
    assign SR        = ir[RA_W-1:0];
    assign err       = err_q;
    assign instr_cnt = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wait_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        err_d   = err_q;
        cnt_d   = cnt_q;
        pending = 1'b0;
        mem_op  = 1'b0;
        ld_pc   = 1'b0;
        in_pc   = 1'b0;
        s       = 2'b00;
        ram_re  = 1'b0;
        ram_we  = 1'b0;
        ld_ir   = 1'b0;
        reg_we  = 1'b0;
        au_en   = 1'b0;
        g_en    = 1'b0;
        in_en   = 1'b0;
        out_en  = 1'b0;
        s0      = 1'b0;
        sm      = 1'b0;
        busy    = 1'b0;
        halted  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end

            StFetch: begin
                busy    = 1'b1;
                ram_re  = 1'b1;
                pending = 1'b1;
                if (mem_ready) begin
                    ld_ir   = 1'b1;
                    in_pc   = 1'b1;
                    state_d = StExec;
                end
            end

            StExec: begin
                busy = 1'b1;
                sm   = 1'b1;
                case (opcode)
                    OpMova: begin s0 = 1'b1; reg_we = 1'b1; au_en = 1'b1; end
                    OpMovd: reg_we = 1'b1;
                    OpAdd:  begin s0 = 1'b1; reg_we = 1'b1; au_en = 1'b1; end
                    OpSub:  begin s0 = 1'b1; reg_we = 1'b1; au_en = 1'b1; g_en = 1'b1; end
                    OpIn:   begin s0 = 1'b1; reg_we = 1'b1; in_en = 1'b1; end
                    OpOut:  begin au_en = 1'b1; out_en = 1'b1; end
                    OpJmp:  ld_pc = 1'b1;
                    OpJg:   ld_pc = gf;
                    OpMovb: begin
                        mem_op = 1'b1;
                        s      = 2'b10;
                        ram_we = 1'b1;
                        au_en  = 1'b1;
                    end
                    OpMovc: begin
                        mem_op = 1'b1;
                        s      = 2'b01;
                        ram_re = 1'b1;
                        s0     = 1'b1;
                        reg_we = mem_ready;
                    end
                    OpMovi: begin
                        mem_op = 1'b1;
                        s      = 2'b00;
                        ram_re = 1'b1;
                        s0     = 1'b1;
                        reg_we = mem_ready;
                        in_pc  = mem_ready;
                    end
                    default: ;  // NOP and HALT drive no strobes
                endcase
                pending = mem_op;

                if (!mem_op || mem_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (opcode == OpHalt)  state_d = StHalt;
                    else if (step_mode)    state_d = StIdle;
                    else                   state_d = StFetch;
                end
            end

            StHalt: begin
                halted = 1'b1;
                if (start) begin
                    err_d   = 1'b0;
                    state_d = StFetch;
                end
            end

            default: state_d = StIdle;
        endcase

        // Wait-state tracking; wait_d defaults to zero so any state change or ready clears it.
        if (pending && !mem_ready) begin
            if (wait_q == WaitLast) begin
                err_d   = 1'b1;
                state_d = StHalt;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_controller_seq.sv
module tb_controller_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       step_mode = 1'b0;
    logic [7:0] ir = 8'h00;
    logic       gf = 1'b0;
    logic       mem_ready = 1'b0;

    logic ld_pc, in_pc, ram_re, ram_we, ld_ir, reg_we, au_en, g_en, in_en, out_en, s0;
    logic sm, busy, halted, err;
    logic [1:0] s, DR, SR;
    logic [3:0] ac;
    logic [15:0] instr_cnt;

    logic b_ld_pc, b_in_pc, b_ram_re, b_ram_we, b_ld_ir, b_reg_we, b_au_en, b_g_en;
    logic b_in_en, b_out_en, b_s0, b_sm, b_busy, b_halted, b_err;
    logic [1:0] b_s, b_DR, b_SR;
    logic [3:0] b_ac, b_instr_cnt;

    controller_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .ir(ir), .gf(gf),
        .mem_ready(mem_ready), .ld_pc(ld_pc), .in_pc(in_pc), .s(s), .ram_re(ram_re),
        .ram_we(ram_we), .ld_ir(ld_ir), .reg_we(reg_we), .au_en(au_en), .g_en(g_en),
        .in_en(in_en), .out_en(out_en), .s0(s0), .ac(ac), .DR(DR), .SR(SR), .sm(sm),
        .busy(busy), .halted(halted), .err(err), .instr_cnt(instr_cnt)
    );

    controller_seq #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .ir(ir), .gf(gf),
        .mem_ready(mem_ready), .ld_pc(b_ld_pc), .in_pc(b_in_pc), .s(b_s), .ram_re(b_ram_re),
        .ram_we(b_ram_we), .ld_ir(b_ld_ir), .reg_we(b_reg_we), .au_en(b_au_en),
        .g_en(b_g_en), .in_en(b_in_en), .out_en(b_out_en), .s0(b_s0), .ac(b_ac), .DR(b_DR),
        .SR(b_SR), .sm(b_sm), .busy(b_busy), .halted(b_halted), .err(b_err),
        .instr_cnt(b_instr_cnt)
    );

    always #5 clk = ~clk;

    logic [40:0] obs_a;
    logic [28:0] obs_b;
    assign obs_a = {ld_pc, in_pc, s, ram_re, ram_we, ld_ir, reg_we, au_en, g_en, in_en, out_en,
                    s0, sm, busy, halted, err, ac, DR, SR, instr_cnt};
    assign obs_b = {b_ld_pc, b_in_pc, b_s, b_ram_re, b_ram_we, b_ld_ir, b_reg_we, b_au_en,
                    b_g_en, b_in_en, b_out_en, b_s0, b_sm, b_busy, b_halted, b_err, b_ac,
                    b_DR, b_SR, b_instr_cnt};

    int total = 0;
    int bad = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic        exp_err = 1'b0;

    // Strobe word: {ld_pc, in_pc, s[1:0], ram_re, ram_we, ld_ir, reg_we, au_en, g_en,
    //               in_en, out_en, s0}
    function automatic logic [12:0] mk(input bit ldpc, input bit inpc, input bit [1:0] ss,
                                       input bit re, input bit we, input bit ldir,
                                       input bit rwe, input bit au, input bit g,
                                       input bit inn, input bit outt, input bit s0b);
        return {ldpc, inpc, ss, re, we, ldir, rwe, au, g, inn, outt, s0b};
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic        gf;
        logic        gf_x;   // gf don't care
        logic        rdy;
        logic        rdy_x;  // mem_ready don't care
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [3:0] op, input logic g, input logic gx,
                                input logic r, input logic rx, input logic [12:0] e);
        vec_t v;
        v.op = op; v.gf = g; v.gf_x = gx; v.rdy = r; v.rdy_x = rx; v.exp = e;
        tbl.push_back(v);
    endfunction

    function automatic logic [12:0] look(input logic [3:0] op, input logic g, input logic r);
        foreach (tbl[i])
            if (tbl[i].op == op && (tbl[i].gf_x || tbl[i].gf == g) &&
                (tbl[i].rdy_x || tbl[i].rdy == r))
                return tbl[i].exp;
        return 13'h1fff;
    endfunction

    function automatic bit is_mem(input logic [3:0] op);
        return op == 4'd1 || op == 4'd2 || op == 4'd10;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [12:0] st, input logic sm_e,
                       input logic busy_e, input logic halt_e);
        logic [40:0] ea;
        logic [28:0] eb;
        @(negedge clk);
        ea = {st, sm_e, busy_e, halt_e, exp_err, ir[7:4], ir[3:2], ir[1:0], exp_cnt};
        eb = {st, sm_e, busy_e, halt_e, exp_err, ir[7:4], ir[3:2], ir[1:0], exp_cnt[3:0]};
        total++;
        if (obs_a !== ea) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, obs_a, ea);
        end
        total++;
        if (obs_b !== eb) begin
            bad++;
            $display("FAIL %s (cnt4): got %h want %h", nm, obs_b, eb);
        end
    endtask

    task automatic do_start(input bit from_halt);
        start = 1'b1;
        mem_ready = 1'($urandom);
        chk(from_halt ? "halt_start" : "idle_start", 13'h0, 1'b0, 1'b0, from_halt);
        tick();
        start = 1'b0;
        mem_ready = 1'b0;
        if (from_halt) exp_err = 1'b0;
    endtask

    // One instruction starting in FETCH; nf/ne are wait cycles on each access.
    task automatic run_instr(input logic [3:0] op, input logic g, input int nf, input int ne,
                             input bit step);
        logic [12:0] f_req, f_done;
        f_req  = mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        f_done = mk(0, 1, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        step_mode = step;
        ir = 8'($urandom);
        gf = 1'($urandom);
        for (int i = 0; i < nf; i++) begin
            mem_ready = 1'b0;
            chk("fetch_wait", f_req, 1'b0, 1'b1, 1'b0);
            tick();
        end
        mem_ready = 1'b1;
        chk("fetch", f_done, 1'b0, 1'b1, 1'b0);
        tick();
        ir = {op, 4'($urandom)};
        gf = g;
        if (is_mem(op)) begin
            for (int i = 0; i < ne; i++) begin
                mem_ready = 1'b0;
                chk("exec_wait", look(op, g, 1'b0), 1'b1, 1'b1, 1'b0);
                tick();
            end
            mem_ready = 1'b1;
            chk("exec_mem", look(op, g, 1'b1), 1'b1, 1'b1, 1'b0);
        end else begin
            mem_ready = 1'($urandom);
            chk("exec", look(op, g, mem_ready), 1'b1, 1'b1, 1'b0);
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        mem_ready = 1'b0;
    endtask

    // Return to FETCH after an instruction that left it.
    task automatic post(input logic [3:0] op, input bit step);
        if (op == 4'd15) do_start(1'b1);
        else if (step) do_start(1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] op;
        bit st;
        add(4'd0,  0, 1, 0, 1, mk(0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        add(4'd1,  0, 1, 0, 1, mk(0, 0, 2'b10, 0, 1, 0, 0, 1, 0, 0, 0, 0));
        add(4'd2,  0, 1, 0, 0, mk(0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        add(4'd2,  0, 1, 1, 0, mk(0, 0, 2'b01, 1, 0, 0, 1, 0, 0, 0, 0, 1));
        add(4'd3,  0, 1, 0, 1, mk(0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        add(4'd4,  0, 1, 0, 1, mk(0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0, 1));
        add(4'd5,  0, 1, 0, 1, mk(0, 0, 2'b00, 0, 0, 0, 1, 1, 1, 0, 0, 1));
        add(4'd6,  0, 1, 0, 1, mk(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(4'd7,  0, 0, 0, 1, mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(4'd7,  1, 0, 0, 1, mk(1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        add(4'd8,  0, 1, 0, 1, mk(0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 1, 0, 1));
        add(4'd9,  0, 1, 0, 1, mk(0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 1, 0));
        add(4'd10, 0, 1, 0, 0, mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        add(4'd10, 0, 1, 1, 0, mk(0, 1, 2'b00, 1, 0, 0, 1, 0, 0, 0, 0, 1));
        add(4'd11, 0, 1, 0, 1, 13'h0);
        add(4'd12, 0, 1, 0, 1, 13'h0);
        add(4'd13, 0, 1, 0, 1, 13'h0);
        add(4'd14, 0, 1, 0, 1, 13'h0);
        add(4'd15, 0, 1, 0, 1, 13'h0);

        // Reset and idle.
        tick();
        chk("reset", 13'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("idle", 13'h0, 1'b0, 1'b0, 1'b0);
        tick();

        // MOVI then ADD, zero waits.
        do_start(1'b0);
        run_instr(4'd10, 1'b0, 0, 0, 1'b0);
        run_instr(4'd4, 1'b0, 0, 0, 1'b0);
        total++;
        if (instr_cnt !== 16'd2) begin
            bad++;
            $display("FAIL movi_add_cnt: got %0d want 2", instr_cnt);
        end

        // MOVC with three wait cycles.
        run_instr(4'd2, 1'b0, 0, 3, 1'b0);

        // MOVB never acknowledged: timeout into HALT.
        ir = 8'h00;
        mem_ready = 1'b1;
        chk("to_fetch", mk(0, 1, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0);
        tick();
        ir = 8'h1b;
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk("to_wait", look(4'd1, 1'b0, 1'b0), 1'b1, 1'b1, 1'b0);
            tick();
        end
        exp_err = 1'b1;
        chk("to_halt", 13'h0, 1'b0, 1'b0, 1'b1);
        tick();
        do_start(1'b1);

        // JG not taken, JG taken, JMP.
        run_instr(4'd7, 1'b0, 1, 0, 1'b0);
        run_instr(4'd7, 1'b1, 0, 0, 1'b0);
        run_instr(4'd6, 1'b0, 0, 0, 1'b0);

        // Single-step over three NOPs.
        for (int k = 0; k < 3; k++) begin
            run_instr(4'(11 + k), 1'b0, 0, 0, 1'b1);
            start = 1'b0;
            chk("step_idle", 13'h0, 1'b0, 1'b0, 1'b0);
            tick();
            do_start(1'b0);
        end
        step_mode = 1'b0;

        // Table of per-opcode EXEC strobes, one instruction per record.
        foreach (tbl[i]) begin
            op = tbl[i].op;
            run_instr(op, tbl[i].gf, 0, (is_mem(op) && !tbl[i].rdy) ? 1 : 0, 1'b0);
            post(op, 1'b0);
        end

        // Random programs with random wait states and step mode.
        for (int n = 0; n < 80; n++) begin
            op = 4'($urandom);
            st = ($urandom_range(0, 3) == 0);
            run_instr(op, 1'($urandom), $urandom_range(0, 14) % ($urandom_range(0, 1) ? 15 : 3),
                      $urandom_range(0, 14) % ($urandom_range(0, 1) ? 15 : 3), st);
            post(op, st);
        end
        step_mode = 1'b0;

        // Asynchronous reset in the middle of FETCH.
        mem_ready = 1'b0;
        chk("pre_reset_fetch", mk(0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        exp_cnt = 16'd0;
        exp_err = 1'b0;
        #1;
        total++;
        if (obs_a !== {13'h0, 4'h0, ir, 16'h0}) begin
            bad++;
            $display("FAIL async_reset: got %h want %h", obs_a, {13'h0, 4'h0, ir, 16'h0});
        end
        chk("in_reset", 13'h0, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        chk("post_reset", 13'h0, 1'b0, 1'b0, 1'b0);
        tick();

        // 17 NOPs: the 4-bit counter wraps to 1.
        do_start(1'b0);
        for (int k = 0; k < 17; k++) run_instr(4'd11, 1'b0, 0, 0, 1'b0);
        total++;
        if (b_instr_cnt !== 4'd1 || instr_cnt !== 16'd17) begin
            bad++;
            $display("FAIL wrap: got %0d/%0d want 1/17", b_instr_cnt, instr_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
